urt_tx: RTL and testbench

URT_TX -- requirements
Module: urt_tx

---
 rtl/urt_pkg.sv | 30 +++
 rtl/urt_tx_serializer.sv | 37 +++
 rtl/urt_tx.sv | 123 ++++++++++++
 tb/tb_urt_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/urt_pkg.sv
// UART transmitter shared types: FSM states, parity types, frame sizes.
// Optional parity frame bit is enabled by defining URT_TX_PARITY_EN.
package urt_pkg;

  localparam int DATA_BITS = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  typedef struct packed {
    logic par_en;
    logic par_typ;
  } tx_cfg_t;

  function automatic logic par_bit(
    input logic [DATA_BITS-1:0] d,
    input logic                 typ
  );
    return (^d) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/urt_tx_serializer.sv
// Byte holding register rotated LSB-first plus the 3-bit data bit counter.
// Rotating (not shifting) leaves the byte intact after eight steps.
module urt_tx_serializer
  import urt_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 rot,
  input  logic                 cnt_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 bit0,
  output logic [2:0]           cnt,
  output logic                 last
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (load)
        data <= din;
      else if (rot)
        data <= {data[0], data[DATA_BITS-1:1]};
      if (load)
        cnt <= '0;
      else if (cnt_en)
        cnt <= cnt + 3'd1;
    end
  end

  assign bit0 = data[0];
  assign last = (cnt == 3'(DATA_BITS - 1));

endmodule

// File: rtl/urt_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Parity bit present only when URT_TX_PARITY_EN is defined.
module urt_tx
  import urt_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_OUT,
  output logic       Busy
);

  tx_state_t state;

  logic       accept;
  logic       rot;
  logic       cnt_en;
  logic [7:0] ser_data;
  logic       bit0;
  logic [2:0] cnt;
  logic       last;

  assign accept = DATA_VALID &&
                  (state == IDLE || state == STOP);
  assign rot    = (state == START) ||
                  (state == DATA && !last);
  assign cnt_en = (state == DATA);

  urt_tx_serializer u_ser (
    .CLK    (CLK),
    .RST    (RST),
    .load   (accept),
    .din    (P_DATA),
    .rot    (rot),
    .cnt_en (cnt_en),
    .data   (ser_data),
    .bit0   (bit0),
    .cnt    (cnt),
    .last   (last)
  );

`ifdef URT_TX_PARITY_EN
  tx_cfg_t cfg;

  always_ff @(posedge CLK) begin
    if (RST)
      cfg <= '0;
    else if (accept)
      cfg <= '{par_en: PAR_EN, par_typ: PAR_TYP};
  end

  logic [2:0] unused_cnt;
  assign unused_cnt = cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{PAR_EN, PAR_TYP,
                        ser_data[7:1], cnt};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (DATA_VALID) begin
            state  <= START;
            TX_OUT <= 1'b0;
            Busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= bit0;
          Busy   <= 1'b1;
        end
        DATA: begin
          Busy <= 1'b1;
          if (!last) begin
            TX_OUT <= bit0;
          end else begin
`ifdef URT_TX_PARITY_EN
            if (cfg.par_en) begin
              state  <= PARITY;
              TX_OUT <= par_bit(ser_data,
                                cfg.par_typ);
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
`else
            state  <= STOP;
            TX_OUT <= 1'b1;
`endif
          end
        end
`ifdef URT_TX_PARITY_EN
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
          Busy   <= 1'b1;
        end
`endif
        // unused encodings fall back to idle
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urt_tx.sv
// Self-checking bench for urt_tx against a queue-based line model.
// Model honours URT_TX_PARITY_EN the same way the build does.
module tb_urt_tx;

`ifdef URT_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int n_cmp = 0;
  int n_err = 0;

  bit line[$];
  bit exp_tx;
  bit exp_busy;

  always #5 CLK = ~CLK;

  urt_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // line model: a whole frame is queued on acceptance
  task automatic model(input logic r,
                       input logic dv,
                       input logic [7:0] d,
                       input logic pe,
                       input logic pt);
    int ones;
    if (r) begin
      line.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (line.size() == 0 && dv) begin
        ones = 0;
        line.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
          line.push_back(d[i]);
          ones += int'(d[i]);
        end
        if (PAR_ON && pe)
          line.push_back(((ones % 2) == 1) ^ pt);
        line.push_back(1'b1);
      end
      if (line.size() != 0) begin
        exp_tx   = line.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic r,
                     input logic dv,
                     input logic [7:0] d,
                     input logic pe,
                     input logic pt);
    @(negedge CLK);
    RST        = r;
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    @(posedge CLK);
    model(r, dv, d, pe, pt);
    #1;
    chk("tx", TX_OUT, exp_tx);
    chk("busy", Busy, exp_busy);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pe,
                            input logic pt,
                            input string tag);
    int n;
    n = 0;
    cyc(0, 1, d, pe, pt);
    if (Busy) n++;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, d, pe, pt);
      if (Busy) n++;
    end
    chk(tag, n, 10 + ((PAR_ON && pe) ? 1 : 0));
  endtask

  initial begin
    int gaps;
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'hFF, 1, 1);
    cyc(1, 0, 8'h00, 0, 0);

    send_frame(8'hA5, 0, 0, "len_a5");
    send_frame(8'hA5, 1, 0, "len_a5_even");
    send_frame(8'hA5, 1, 1, "len_a5_odd");
    send_frame(8'h01, 1, 0, "len_01_even");
    send_frame(8'h00, 1, 0, "len_00_even");

    // back-to-back: valid held through the frame
    gaps = 0;
    cyc(0, 1, 8'h55, 0, 0);
    if (!Busy) gaps++;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 8'h55, 0, 0);
      if (!Busy) gaps++;
    end
    cyc(0, 1, 8'h0F, 0, 0);
    if (!Busy) gaps++;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 8'h00, 0, 0);
      if (!Busy) gaps++;
    end
    chk("b2b_gap", gaps, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 8'h00, 0, 0);
    chk("b2b_idle", Busy, 0);

    // valid during data is ignored
    cyc(0, 1, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'hFF, 1, 1);
    for (int i = 0; i < 15; i++)
      cyc(0, 0, 8'h00, 0, 0);

    // reset at data bit 3
    cyc(0, 1, 8'hC3, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'hFF, 0, 0);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", Busy, 0);
    send_frame(8'h3C, 1, 1, "len_after_rst");

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 79) == 0,
          $urandom_range(0, 3) == 0,
          8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
